// File: rtl/tsn_tx_pkg.sv
// Shared constants and types for the TX byte serializer.
// Imported by the serializer top.
package tsn_tx_pkg;

  localparam int WORD_W = 64;
  localparam int BCNT_W = 3;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [2:0] PRE_CNT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_IFG  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] byte_sel(
    input logic [WORD_W-1:0] w,
    input logic [BCNT_W-1:0] idx
  );
    logic [WORD_W-1:0] s;
    s = w << {idx, 3'b000};
    return s[WORD_W-1 -: 8];
  endfunction

  // Index of the final valid byte held in a word.
  function automatic logic [BCNT_W-1:0] last_idx(
    input logic              eop,
    input logic [BCNT_W-1:0] bytes
  );
    if (!eop || bytes == '0) return 3'd7;
    return bytes - 3'd1;
  endfunction

endpackage

// File: rtl/network_tx_serializer.sv
// Packet word to byte-stream serializer with preamble/SFD
// insertion, inter-frame gap and underrun/protocol reporting.
module network_tx_serializer
  import tsn_tx_pkg::*;
#(
  parameter int P_IFG         = 12,
  parameter bit P_PREAMBLE_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WORD_W-1:0] iv_word_data,
  input  logic              i_word_valid,
  input  logic              i_word_sop,
  input  logic              i_word_eop,
  input  logic [BCNT_W-1:0] iv_word_bytes,
  output logic              o_word_ready,
  output logic [7:0]        ov_pkt_data,
  output logic              o_pkt_data_wr,
  output logic              o_underrun_pulse,
  output logic              o_proto_err_pulse,
  output logic [31:0]       ov_tx_pkt_cnt
);

  localparam logic [7:0] GAP_END = 8'(P_IFG - 1);

  tx_state_e state_q, state_d;

  logic [WORD_W-1:0] buf_data_q;
  logic              buf_valid_q;
  logic              buf_sop_q;
  logic              buf_eop_q;
  logic [BCNT_W-1:0] buf_last_q;
  logic [BCNT_W-1:0] ptr_q, ptr_d;
  logic [2:0]        pre_q, pre_d;
  logic [7:0]        gap_q, gap_d;
  logic              stall_q, stall_d;

  logic [7:0]  data_d;
  logic        wr_d, und_d, err_d;
  logic [31:0] cnt_d;
  logic        last_byte, accept, consume, emit;

  assign last_byte = (ptr_q == buf_last_q);

  assign o_word_ready = !buf_valid_q |
    (state_q == ST_DATA & buf_valid_q & last_byte & !buf_eop_q);

  assign accept = i_word_valid & o_word_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pre_d   = pre_q;
    gap_d   = gap_q;
    stall_d = stall_q;
    data_d  = 8'h00;
    wr_d    = 1'b0;
    und_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = ov_tx_pkt_cnt;
    consume = 1'b0;
    emit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (buf_valid_q) begin
          if (!buf_sop_q) begin
            consume = 1'b1;
            err_d   = 1'b1;
          end else if (P_PREAMBLE_EN) begin
            data_d  = PRE_BYTE;
            wr_d    = 1'b1;
            pre_d   = 3'd1;
            state_d = ST_PRE;
          end else begin
            emit = 1'b1;
          end
        end
      end
      ST_PRE: begin
        wr_d = 1'b1;
        if (pre_q == PRE_CNT) begin
          data_d  = SFD_BYTE;
          state_d = ST_DATA;
        end else begin
          data_d = PRE_BYTE;
          pre_d  = pre_q + 3'd1;
        end
      end
      ST_DATA: begin
        if (buf_valid_q) begin
          emit = 1'b1;
        end else begin
          // One pulse per stall, however long it lasts.
          und_d   = !stall_q;
          stall_d = 1'b1;
        end
      end
      ST_IFG: begin
        if (gap_q == GAP_END) state_d = ST_IDLE;
        else gap_d = gap_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      data_d  = byte_sel(buf_data_q, ptr_q);
      wr_d    = 1'b1;
      stall_d = 1'b0;
      state_d = ST_DATA;
      if (last_byte) begin
        consume = 1'b1;
        ptr_d   = '0;
        if (buf_eop_q) begin
          cnt_d   = ov_tx_pkt_cnt + 32'd1;
          gap_d   = 8'd0;
          state_d = ST_IFG;
        end
      end else begin
        ptr_d = ptr_q + 3'd1;
      end
    end

    if (accept & i_word_sop & state_q == ST_DATA) err_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      pre_q   <= '0;
      gap_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pre_q   <= pre_d;
      gap_q   <= gap_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      buf_sop_q   <= 1'b0;
      buf_eop_q   <= 1'b0;
      buf_last_q  <= '0;
    end else if (accept) begin
      buf_data_q  <= iv_word_data;
      buf_valid_q <= 1'b1;
      buf_sop_q   <= i_word_sop;
      buf_eop_q   <= i_word_eop;
      buf_last_q  <= last_idx(i_word_eop, iv_word_bytes);
    end else if (consume) begin
      buf_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_pkt_data       <= '0;
      o_pkt_data_wr     <= 1'b0;
      o_underrun_pulse  <= 1'b0;
      o_proto_err_pulse <= 1'b0;
      ov_tx_pkt_cnt     <= '0;
    end else begin
      ov_pkt_data       <= data_d;
      o_pkt_data_wr     <= wr_d;
      o_underrun_pulse  <= und_d;
      o_proto_err_pulse <= err_d;
      ov_tx_pkt_cnt     <= cnt_d;
    end
  end

endmodule
